serial_parity_rx: RTL and testbench

- Serial frame receiver with parity checking. It is the receive end of the team's parity-protected serial link.
- It takes a bit-serial line qualified by a bit-enable strobe and deserialises start/data/parity/stop frames.
- It checks parity with an XNOR/XOR reduction and presents the parallel word with status flags.
- Position: between the line synchroniser/bit-timing logic (which generates bit_en) and the consumer of the received bytes.

---
 rtl/serial_parity_rx_pkg.sv | 28 ++
 rtl/serial_parity_rx_parity_acc.sv | 22 ++
 rtl/serial_parity_rx.sv | 141 ++++++++++++++
 tb/tb_serial_parity_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_rx_pkg.sv
// Shared state encoding, parity-mode and frame-length definitions for both ends
// of the parity-protected serial link.
package serial_parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 16;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_status_t;

  // Line bits per frame: start + data + parity + stop.
  function automatic int frame_bits(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// Running XOR accumulator with clear and enable; clear wins over enable.
// Result is available the cycle after the enabling edge; no backpressure.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic sample,
  output logic acc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ sample;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Start/data/parity/stop deserialiser with parity and stop-bit checks; result
// registered one cycle after the stop-bit sample, no backpressure (line-paced).
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
    $error("serial_parity_rx: DATA_W out of range");
  end

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic            PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic              pe_q;
  logic              pe_nxt;
  logic              run_par;
  logic [DATA_W-1:0] data_q;
  rx_status_t        status_q;
  logic              valid_q;

  logic cnt_clr;
  logic cnt_inc;
  logic shift_en;
  logic par_clr;
  logic par_en;
  logic pe_ld;
  logic deliver;

  parity_acc u_parity_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (par_clr),
    .en     (par_en),
    .sample (rx_in),
    .acc    (run_par)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_en  = 1'b0;
    par_clr   = 1'b0;
    par_en    = 1'b0;
    pe_ld     = 1'b0;
    deliver   = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!rx_in) begin
            state_nxt = DATA;
            cnt_clr   = 1'b1;
            par_clr   = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          par_en   = 1'b1;
          cnt_inc  = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          pe_ld     = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // LSB arrives first, so new bits enter at the top and walk down to bit 0.
  always_comb begin
    shift_nxt             = shift_q >> 1;
    shift_nxt[DATA_W-1]   = rx_in;
    pe_nxt                = run_par ^ rx_in ^ PAR_MODE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shift_q  <= '0;
      pe_q     <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= deliver;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (shift_en) begin
        shift_q <= shift_nxt;
      end
      if (pe_ld) begin
        pe_q <= pe_nxt;
      end
      // Word is delivered regardless of errors; the consumer decides.
      if (deliver) begin
        data_q              <= shift_q;
        status_q.parity_err <= pe_q;
        status_q.frame_err  <= ~rx_in;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = status_q.parity_err;
  assign frame_err  = status_q.frame_err;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Randomised bench for serial_parity_rx: even and odd instances share one line
// and are scored against a frame-level parity/stop model.
`timescale 1ns/1ps
module tb_serial_parity_rx;
  import serial_parity_rx_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          bit_en;
  logic          rx_in;
  logic [DW-1:0] dout_e, dout_o;
  logic          dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
    .frame_err(fe_e), .busy(busy_e)
  );

  serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
    .frame_err(fe_o), .busy(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          fe;
    int            at;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  int   vcyc_e[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level rule: total ones over data+parity must be even (even mode) or odd.
  function automatic exp_t model(input logic [DW-1:0] d, input logic p, input logic s,
                                 input bit odd, input int at);
    exp_t e;
    int   ones;
    ones   = $countones(d) + int'(p);
    e.data = d;
    e.pe   = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    e.fe   = !s;
    e.at   = at;
    return e;
  endfunction

  always @(negedge clk) begin
    if (dv_e) begin
      vcyc_e.push_back(cyc);
      if (q_e.size() == 0) begin
        chk("even_spurious_valid", 1, 0);
      end else begin
        chk("even_data", 32'(dout_e), 32'(q_e[0].data));
        chk("even_parity_err", 32'(pe_e), 32'(q_e[0].pe));
        chk("even_frame_err", 32'(fe_e), 32'(q_e[0].fe));
        chk("even_latency", cyc, q_e[0].at);
        q_e.delete(0);
      end
    end
    if (dv_o) begin
      if (q_o.size() == 0) begin
        chk("odd_spurious_valid", 1, 0);
      end else begin
        chk("odd_data", 32'(dout_o), 32'(q_o[0].data));
        chk("odd_parity_err", 32'(pe_o), 32'(q_o[0].pe));
        chk("odd_frame_err", 32'(fe_o), 32'(q_o[0].fe));
        chk("odd_latency", cyc, q_o[0].at);
        q_o.delete(0);
      end
    end
  end

  // One line bit: gap-1 cycles with bit_en low (line noise ignored), then the strobe.
  task automatic strobe(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i == gap - 1) begin
        bit_en = 1'b1;
        rx_in  = b;
      end else begin
        bit_en = 1'b0;
        rx_in  = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
      rx_in  = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < DW; i++) begin
      strobe(d[i], gap);
      if (i == 0) begin
        chk("even_busy_in_frame", 32'(busy_e), 1);
        chk("odd_busy_in_frame", 32'(busy_o), 1);
      end
    end
    strobe(p, gap);
    strobe(s, gap);
    q_e.push_back(model(d, p, s, 1'b0, cyc + 1));
    q_o.push_back(model(d, p, s, 1'b1, cyc + 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
      rx_in  = 1'b1;
      if (q_e.size() == 0 && q_o.size() == 0) break;
    end
    chk("even_drain_pending", q_e.size(), 0);
    chk("odd_drain_pending", q_o.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            gap;

    rst_n  = 1'b0;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(dout_e), 0);
    chk("rst_data_valid", 32'(dv_e), 0);
    chk("rst_parity_err", 32'(pe_e), 0);
    chk("rst_frame_err", 32'(fe_e), 0);
    chk("rst_busy", 32'(busy_e), 0);
    chk("rst_busy_odd", 32'(busy_o), 0);
    rst_n = 1'b1;

    // Idle line: strobes with rx_in high never start a frame.
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, $urandom_range(1, 3));
      chk("idle_busy", 32'(busy_e | busy_o), 0);
    end
    idle(2);
    chk("idle_busy_end", 32'(busy_e | busy_o), 0);
    chk("idle_data_out", 32'(dout_e), 0);
    chk("idle_parity_err", 32'(pe_e | pe_o), 0);
    chk("idle_frame_err", 32'(fe_e | fe_o), 0);

    send_frame(8'hA5, 1'b0, 1'b1, 4);
    drain();
    idle(5);
    chk("hold_data_out", 32'(dout_e), 32'h0A5);
    chk("hold_parity_err_even", 32'(pe_e), 0);
    chk("hold_parity_err_odd", 32'(pe_o), 1);
    chk("hold_frame_err", 32'(fe_e), 0);

    send_frame(8'hA5, 1'b1, 1'b1, 4);
    drain();
    send_frame(8'h00, 1'b1, 1'b0, 3);
    drain();

    vcyc_e.delete();
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    send_frame(8'hC3, 1'b0, 1'b1, 1);
    drain();
    chk("b2b_pulse_count", vcyc_e.size(), 2);
    if (vcyc_e.size() == 2) begin
      chk("b2b_spacing", vcyc_e[1] - vcyc_e[0], frame_bits(DW));
    end

    // Reset in the middle of a frame discards it.
    strobe(1'b0, 2);
    for (int i = 0; i < 4; i++) strobe(1'b1, 2);
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_e | busy_o), 0);
    chk("midrst_data_out", 32'(dout_e), 0);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_busy_after", 32'(busy_e | busy_o), 0);
    send_frame(8'h81, 1'b0, 1'b1, 2);
    drain();
    chk("post_rst_data_out", 32'(dout_e), 32'h081);

    // Break frame followed immediately by a new start bit.
    send_frame(8'h00, 1'b0, 1'b0, 1);
    send_frame(8'h5A, 1'b1, 1'b1, 1);
    drain();

    for (int n = 0; n < 40; n++) begin
      d   = DW'($urandom);
      gap = $urandom_range(1, 4);
      send_frame(d, 1'($urandom), ($urandom_range(0, 3) != 0), gap);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) strobe(1'b1, gap);
      if ($urandom_range(0, 4) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
